// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - edge qualifier modes and helper
//
// Purpose: the per-channel event qualifier enum and the function that applies
// it to a rise/fall pair.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_t;

  function automatic logic edge_qualify(edge_mode_t mode, logic rise, logic fall);
    logic q;
    case (mode)
      EDGE_RISE: q = rise;
      EDGE_FALL: q = fall;
      EDGE_BOTH: q = rise | fall;
      default:   q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/sys_structs.sv
// rtl/sys_structs.sv - shared clock-domain bundle type
//
// Purpose: groups one clock with its enable and synchronous reset so blocks
// take a single clock-domain port.
// Types:
//   clk_domain.clk      - clock
//   clk_domain.clk_en   - clock enable; state advances only when high
//   clk_domain.sync_rst - synchronous, active-high reset
package sys_structs;

  typedef struct packed {
    logic clk;
    logic clk_en;
    logic sync_rst;
  } clk_domain;

endpackage

// File: rtl/edge_filter_channel.sv
// rtl/edge_filter_channel.sv - one debounced edge/event/pending channel
//
// Purpose: filters one synchronous input level, emits rise/fall pulses on
// accepted level changes, qualifies them by mode and keeps a sticky flag.
// Ports:
//   clk, clk_en, sync_rst - clock, enable, synchronous active-high reset
//   sense                 - raw level
//   ch_en                 - channel enable; low forces the filter to 0 silently
//   mode                  - event qualifier
//   clear                 - write-1-to-clear for pending
//   level                 - filtered level (never delayed by the buffer stage)
//   rise, fall, evt       - one-enabled-cycle pulses
//   pending               - sticky event flag
module edge_filter_channel
  import edge_pkg::*;
#(
  parameter int FILTER_CYCLES = 4,
  parameter bit BUFFERED      = 1'b0
) (
  input  logic       clk,
  input  logic       clk_en,
  input  logic       sync_rst,
  input  logic       sense,
  input  logic       ch_en,
  input  edge_mode_t mode,
  input  logic       clear,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       evt,
  output logic       pending
);

  localparam int            CW   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_d, fall_d, evt_d;
  logic          rise_q, fall_q, evt_q;
  logic          pending_q;
  logic          set_pend;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!ch_en) begin
      // Disabled channels drop to 0 without reporting a fall.
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (sense == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      level_d = sense;
      cnt_d   = '0;
      rise_d  = sense;
      fall_d  = ~sense;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    evt_d = edge_qualify(mode, rise_d, fall_d);
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      evt_q     <= 1'b0;
      pending_q <= 1'b0;
    end else if (clk_en) begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      evt_q     <= evt_d;
      // Set wins over a coinciding clear.
      pending_q <= (pending_q & ~clear) | set_pend;
    end
  end

  // Pending is fed from whichever stage drives evt, so it rises with evt.
  if (BUFFERED) begin : g_buf
    logic rise_b, fall_b, evt_b;
    always_ff @(posedge clk) begin
      if (sync_rst) begin
        rise_b <= 1'b0;
        fall_b <= 1'b0;
        evt_b  <= 1'b0;
      end else if (clk_en) begin
        rise_b <= rise_q;
        fall_b <= fall_q;
        evt_b  <= evt_q;
      end
    end
    assign rise     = rise_b;
    assign fall     = fall_b;
    assign evt      = evt_b;
    assign set_pend = evt_q;
  end else begin : g_nobuf
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign evt      = evt_q;
    assign set_pend = evt_d;
  end

  assign level   = level_q;
  assign pending = pending_q;

endmodule

// File: rtl/edge_event_array.sv
// rtl/edge_event_array.sv - array of independent debounced edge-event channels
//
// Purpose: CHANNELS copies of edge_filter_channel plus the interrupt OR.
// Ports:
//   clk_dom_i  - clock, clock enable, synchronous active-high reset
//   sense_i    - raw levels, synchronous to clk
//   ch_en_i    - per-channel enable
//   mode_i     - per-channel event qualifier
//   clear_i    - write-1-to-clear mask for pending_o
//   level_o    - filtered levels
//   rise_o     - filtered 0->1 pulses
//   fall_o     - filtered 1->0 pulses
//   event_o    - mode-qualified pulses
//   pending_o  - sticky event flags
//   irq_o      - OR of pending_o
module edge_event_array
  import edge_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int FILTER_CYCLES = 4,
  parameter bit BUFFERED      = 1'b0
) (
  input  sys_structs::clk_domain      clk_dom_i,
  input  logic       [CHANNELS-1:0]   sense_i,
  input  logic       [CHANNELS-1:0]   ch_en_i,
  input  edge_mode_t [CHANNELS-1:0]   mode_i,
  input  logic       [CHANNELS-1:0]   clear_i,
  output logic       [CHANNELS-1:0]   level_o,
  output logic       [CHANNELS-1:0]   rise_o,
  output logic       [CHANNELS-1:0]   fall_o,
  output logic       [CHANNELS-1:0]   event_o,
  output logic       [CHANNELS-1:0]   pending_o,
  output logic                        irq_o
);

  if (CHANNELS < 1 || CHANNELS > 32 || FILTER_CYCLES < 1) begin : g_param_check
    $error("edge_event_array: CHANNELS must be 1..32 and FILTER_CYCLES >= 1");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_filter_channel #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .BUFFERED     (BUFFERED)
    ) u_ch (
      .clk     (clk_dom_i.clk),
      .clk_en  (clk_dom_i.clk_en),
      .sync_rst(clk_dom_i.sync_rst),
      .sense   (sense_i[g]),
      .ch_en   (ch_en_i[g]),
      .mode    (mode_i[g]),
      .clear   (clear_i[g]),
      .level   (level_o[g]),
      .rise    (rise_o[g]),
      .fall    (fall_o[g]),
      .evt     (event_o[g]),
      .pending (pending_o[g])
    );
  end

  assign irq_o = |pending_o;

endmodule
